// File: rtl/systolic_feeder.sv
// Skewing feeder for one edge of a systolic array: walks a matrix ROM row by row
// and emits each row with lane i delayed i cycles, then zero-flushes the skew.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 3,
  parameter int MEM_DEPTH  = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             hold,
  output logic                             rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0]     addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] rom_data,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  output logic                             busy,
  output logic                             done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int KW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [AW-1:0]   row_addr_q;
  logic            valid_q;
  logic            done_q;

  // Sequencer: IDLE -> FETCH (N rows) -> DRAIN (N-1 flush beats) -> DONE -> IDLE; hold freezes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= {KW{1'b0}};
      row_addr_q <= {AW{1'b0}};
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        IDLE: begin
          valid_q    <= 1'b0;
          done_q     <= 1'b0;
          k_q        <= {KW{1'b0}};
          row_addr_q <= {AW{1'b0}};
          if (start) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          valid_q    <= 1'b1;
          row_addr_q <= row_addr_q + AW'(BLOCK_SIZE);
          if (k_q == KW'(BLOCK_SIZE - 1)) begin
            k_q <= {KW{1'b0}};
            if (BLOCK_SIZE == 1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DRAIN: begin
          valid_q <= 1'b1;
          if (k_q == KW'(BLOCK_SIZE - 2)) begin
            k_q     <= {KW{1'b0}};
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          k_q        <= {KW{1'b0}};
          row_addr_q <= {AW{1'b0}};
          valid_q    <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // The row base address is held through a stall so the ROM address stays stable.
  assign rd_en     = (state_q == FETCH) && !hold;
  assign addr      = (state_q == FETCH) ? row_addr_q : {AW{1'b0}};
  assign valid_out = valid_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] chain_q [0:i];
    logic [DATA_WIDTH-1:0] stage0_d;

    // Stage 0 loads the ROM word during FETCH and zero otherwise so DRAIN flushes the skew.
    always_comb begin
      if (state_q == FETCH) begin
        stage0_d = rom_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        stage0_d = {DATA_WIDTH{1'b0}};
      end
    end

    // Lane i delay line of i+1 registers; cleared on the edge leaving DONE.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= i; j++) begin
          chain_q[j] <= {DATA_WIDTH{1'b0}};
        end
      end else if (!hold) begin
        if (state_q == DONE) begin
          for (int j = 0; j <= i; j++) begin
            chain_q[j] <= {DATA_WIDTH{1'b0}};
          end
        end else if ((state_q == FETCH) || (state_q == DRAIN)) begin
          chain_q[0] <= stage0_d;
          for (int j = 1; j <= i; j++) begin
            chain_q[j] <= chain_q[j-1];
          end
        end
      end
    end

    assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = chain_q[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=3, ROM mem[j] = j+1): records each cycle,
// then every scenario task compares the recording against hand-derived values.
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int N  = 3;
  localparam int MD = 9;
  localparam int AW = 4;
  localparam int MAXC = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              hold;
  logic              rd_en;
  logic [AW-1:0]     addr;
  logic [N*DW-1:0]   rom_data;
  logic [N*DW-1:0]   data_out;
  logic              valid_out;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  logic [N*DW-1:0] exp_beats [0:4];

  logic            v_a  [0:MAXC-1];
  logic [N*DW-1:0] d_a  [0:MAXC-1];
  logic            dn_a [0:MAXC-1];
  logic            bz_a [0:MAXC-1];
  logic            h_a  [0:MAXC-1];
  logic            rd_a [0:MAXC-1];
  logic [AW-1:0]   ad_a [0:MAXC-1];

  logic [N*DW-1:0] beats_q [$];
  int              done_idx [$];
  logic [AW-1:0]   addr_q [$];
  int              busy_cnt;

  systolic_feeder #(.DATA_WIDTH(DW), .BLOCK_SIZE(N), .MEM_DEPTH(MD)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .rd_en(rd_en), .addr(addr), .rom_data(rom_data),
    .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM image: mem[j] = j + 1, a block of N words starting at addr.
  always_comb begin
    rom_data = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(addr) + i < MD) rom_data[i*DW +: DW] = DW'(int'(addr) + i + 1);
    end
  end

  task automatic run(input int ncyc, input int hs, input int hl, input int s2, input int s3);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      v_a[c]  = valid_out;
      d_a[c]  = data_out;
      dn_a[c] = done;
      bz_a[c] = busy;
      start   = (c == 0) || (c == s2) || (c == s3);
      hold    = (c >= hs) && (c < hs + hl);
      h_a[c]  = hold;
      #1;
      rd_a[c] = rd_en;
      ad_a[c] = addr;
    end
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic summarize(input int ncyc);
    beats_q.delete();
    done_idx.delete();
    addr_q.delete();
    busy_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (v_a[c] && !h_a[c]) beats_q.push_back(d_a[c]);
      if (dn_a[c]) done_idx.push_back(c);
      if (rd_a[c]) addr_q.push_back(ad_a[c]);
      if (bz_a[c]) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    #12;
    vectors++;
    if ({data_out, valid_out, busy, done, rd_en, addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got out=%h v=%b b=%b d=%b rd=%b a=%h expected all 0",
               data_out, valid_out, busy, done, rd_en, addr);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({data_out, valid_out, busy, done, rd_en, addr} !== '0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: got out=%h v=%b b=%b d=%b rd=%b a=%h expected all 0",
                 c, data_out, valid_out, busy, done, rd_en, addr);
      end
    end
  endtask

  task automatic test_stream();
    run(10, -1, 0, -1, -1);
    summarize(10);
    vectors++;
    if (addr_q.size() != 3) begin
      miscompares++;
      $display("FAIL stream_rd_count: got %0d expected 3", addr_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (addr_q[k] !== AW'(k * N)) begin
          miscompares++;
          $display("FAIL stream_addr%0d: got %0d expected %0d", k, addr_q[k], k * N);
        end
      end
    end
    vectors++;
    if (v_a[1] !== 1'b0 || v_a[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_first_valid: got v1=%b v2=%b expected 0 1", v_a[1], v_a[2]);
    end
    vectors++;
    if (beats_q.size() != 5) begin
      miscompares++;
      $display("FAIL stream_beat_count: got %0d expected 5", beats_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (beats_q[k] !== exp_beats[k]) begin
          miscompares++;
          $display("FAIL stream_beat%0d: got %h expected %h", k, beats_q[k], exp_beats[k]);
        end
      end
    end
    vectors++;
    if (done_idx.size() != 1 || done_idx[0] != 6 || d_a[6] !== 24'h090000) begin
      miscompares++;
      $display("FAIL stream_done: got count=%0d data@6=%h expected one pulse at cycle 6 with 090000",
               done_idx.size(), d_a[6]);
    end
    vectors++;
    if (busy_cnt != 6) begin
      miscompares++;
      $display("FAIL stream_busy: got %0d cycles expected 6", busy_cnt);
    end
  endtask

  task automatic test_hold();
    run(12, 2, 2, -1, -1);
    summarize(12);
    vectors++;
    if (rd_a[2] !== 1'b0 || rd_a[3] !== 1'b0 || ad_a[2] !== 4'd3) begin
      miscompares++;
      $display("FAIL hold_rd: got rd=%b%b addr=%0d expected rd=00 addr=3", rd_a[2], rd_a[3], ad_a[2]);
    end
    vectors++;
    if (addr_q.size() != 3 || addr_q[0] !== 4'd0 || addr_q[1] !== 4'd3 || addr_q[2] !== 4'd6) begin
      miscompares++;
      $display("FAIL hold_addr_seq: got %0d reads expected 0,3,6", addr_q.size());
    end
    vectors++;
    if (beats_q.size() != 5) begin
      miscompares++;
      $display("FAIL hold_beat_count: got %0d expected 5", beats_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (beats_q[k] !== exp_beats[k]) begin
          miscompares++;
          $display("FAIL hold_beat%0d: got %h expected %h", k, beats_q[k], exp_beats[k]);
        end
      end
    end
    vectors++;
    if (done_idx.size() != 1 || done_idx[0] != 8 || busy_cnt != 8) begin
      miscompares++;
      $display("FAIL hold_done: got count=%0d busy=%0d expected one pulse at cycle 8, busy 8",
               done_idx.size(), busy_cnt);
    end
  endtask

  task automatic test_start_ignored();
    run(12, -1, 0, 2, 6);
    summarize(12);
    vectors++;
    if (beats_q.size() != 5) begin
      miscompares++;
      $display("FAIL ign_beat_count: got %0d expected 5", beats_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (beats_q[k] !== exp_beats[k]) begin
          miscompares++;
          $display("FAIL ign_beat%0d: got %h expected %h", k, beats_q[k], exp_beats[k]);
        end
      end
    end
    vectors++;
    if (done_idx.size() != 1 || done_idx[0] != 6 || busy_cnt != 6) begin
      miscompares++;
      $display("FAIL ign_done: got count=%0d busy=%0d expected one pulse at cycle 6, busy 6",
               done_idx.size(), busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    run(5, -1, 0, -1, -1);
    vectors++;
    if (valid_out !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: got v=%b b=%b expected 1 1", valid_out, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({data_out, valid_out, busy, done, rd_en, addr} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got out=%h v=%b b=%b d=%b rd=%b a=%h expected all 0",
               data_out, valid_out, busy, done, rd_en, addr);
    end
    @(negedge clk);
    reset = 1'b1;
    run(10, -1, 0, -1, -1);
    summarize(10);
    vectors++;
    if (beats_q.size() != 5) begin
      miscompares++;
      $display("FAIL rstmid_beat_count: got %0d expected 5", beats_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (beats_q[k] !== exp_beats[k]) begin
          miscompares++;
          $display("FAIL rstmid_beat%0d: got %h expected %h", k, beats_q[k], exp_beats[k]);
        end
      end
    end
    vectors++;
    if (done_idx.size() != 1 || done_idx[0] != 6) begin
      miscompares++;
      $display("FAIL rstmid_done: got count=%0d expected one pulse at cycle 6", done_idx.size());
    end
  endtask

  task automatic test_back_to_back();
    run(16, -1, 0, 7, -1);
    summarize(16);
    vectors++;
    if (beats_q.size() != 10) begin
      miscompares++;
      $display("FAIL b2b_beat_count: got %0d expected 10", beats_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        vectors++;
        if (beats_q[k] !== exp_beats[k % 5]) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: got %h expected %h", k, beats_q[k], exp_beats[k % 5]);
        end
      end
    end
    vectors++;
    if (done_idx.size() != 2 || done_idx[0] != 6 || done_idx[1] != 13) begin
      miscompares++;
      $display("FAIL b2b_done: got count=%0d expected pulses at cycles 6 and 13", done_idx.size());
    end
    vectors++;
    if (bz_a[6] !== 1'b1 || bz_a[7] !== 1'b0 || bz_a[8] !== 1'b1 || v_a[7] !== 1'b0 || busy_cnt != 12) begin
      miscompares++;
      $display("FAIL b2b_gap: got busy6..8=%b%b%b v7=%b busy=%0d expected 101, 0, 12",
               bz_a[6], bz_a[7], bz_a[8], v_a[7], busy_cnt);
    end
  endtask

  initial begin
    exp_beats[0] = 24'h000001;
    exp_beats[1] = 24'h000204;
    exp_beats[2] = 24'h030507;
    exp_beats[3] = 24'h060800;
    exp_beats[4] = 24'h090000;
    test_reset();
    test_stream();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
